// File: rtl/hazard_ctrl_if.sv
// Hazard controller bundle.
// The "slave" modport is the hazard controller. It takes the pipeline's register
// addresses, the stage control flags and the data-memory handshake. It drives the
// stage stall/flush pairs, the EX forwarding selects and the status outputs
// (mem_err, stall_cnt). The "master" modport is the pipeline side of the same wires.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rs1D, Rs2D;
  logic [1:0]       RegReadD;
  logic [4:0]       Rs1E, Rs2E;
  logic [1:0]       RegReadE;
  logic [4:0]       RdE;
  logic             MemToRegE;
  logic [4:0]       RdM, RdW;
  logic [2:0]       RegWriteM, RegWriteW;
  logic             BranchE, JalrE, JalD;
  logic             dmem_req, dmem_ack;

  logic             StallF, StallD, StallE, StallM, StallW;
  logic             FlushD, FlushE, FlushM, FlushW;
  logic [1:0]       Forward1E, Forward2E;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE, RdE, MemToRegE,
           RdM, RdW, RegWriteM, RegWriteW, BranchE, JalrE, JalD,
           dmem_req, dmem_ack,
    output StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, mem_err, stall_cnt
  );

  modport master (
    output Rs1D, Rs2D, RegReadD, Rs1E, Rs2E, RegReadE, RdE, MemToRegE,
           RdM, RdW, RegWriteM, RegWriteW, BranchE, JalrE, JalD,
           dmem_req, dmem_ack,
    input  StallF, StallD, StallE, StallM, StallW,
           FlushD, FlushE, FlushM, FlushW,
           Forward1E, Forward2E, mem_err, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller.
// This block resolves three kinds of hazard:
//   - load-use stalls;
//   - branch and jump flushes;
//   - multi-cycle data-memory waits. A wait that lasts too long ends in a
//     fatal timeout (HALT).
// It also drives the EX-stage operand forwarding selects. It counts the cycles
// in which ID is stalled.
// Ports:
//   clk  core clock. All state updates on the rising edge.
//   rst  synchronous, active-high reset. While it is high the pipeline drains
//        to bubbles.
//   hz   hazard_ctrl_if.slave. Pipeline inputs, stall/flush/forward outputs,
//        mem_err and stall_cnt.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 256,
  parameter int CNT_W       = 32
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_if.slave   hz
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_next;
  logic                err_set;
  logic                memstall;
  logic                redirect;
  logic                load_use;
  logic                mem_err;
  logic [CNT_W-1:0]    stall_cnt;

  // MEM result has priority over WB because it is the younger write to the register.
  // x0 is hard-wired to zero, so it is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic       used,
    input logic [4:0] rs,
    input logic [4:0] rd_m,
    input logic [2:0] wr_m,
    input logic [4:0] rd_w,
    input logic [2:0] wr_w
  );
    if (used && (wr_m != 3'd0) && (rd_m != 5'd0) && (rd_m == rs))
      return 2'b10;
    else if (used && (wr_w != 3'd0) && (rd_w != 5'd0) && (rd_w == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // ---------------------------------------------------------------- state register
  // NOTE: sequential state uses non-blocking assignments, so every flop
  // samples pre-edge values and the result does not depend on process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // ---------------------------------------------------------------- next state
  // NOTE: every variable gets a default at the top, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    err_set       = 1'b0;
    case (state)
      RUN: begin
        if (hz.dmem_req && !hz.dmem_ack) begin
          state_next    = MWAIT;
          wait_cnt_next = WAIT_W'(1);
        end
      end
      MWAIT: begin
        if (hz.dmem_ack) begin
          state_next    = RUN;
          wait_cnt_next = '0;
        end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
          state_next = HALT;
          err_set    = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt + 1'b1;
        end
      end
      HALT:    state_next = HALT;  // only rst leaves HALT
      default: state_next = RUN;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  // In MWAIT the access is still outstanding even if dmem_req has dropped.
  // Only dmem_ack ends the wait.
  assign memstall = ((state == RUN) && hz.dmem_req && !hz.dmem_ack) ||
                    ((state == MWAIT) && !hz.dmem_ack) ||
                    (state == HALT);

  assign redirect = hz.BranchE || hz.JalrE;
  assign load_use = hz.MemToRegE && (hz.RdE != 5'd0) &&
                    ((hz.RegReadD[1] && (hz.RdE == hz.Rs1D)) ||
                     (hz.RegReadD[0] && (hz.RdE == hz.Rs2D)));

  always_comb begin
    hz.StallF    = 1'b0;
    hz.StallD    = 1'b0;
    hz.StallE    = 1'b0;
    hz.StallM    = 1'b0;
    hz.StallW    = 1'b0;
    hz.FlushD    = 1'b0;
    hz.FlushE    = 1'b0;
    hz.FlushM    = 1'b0;
    hz.FlushW    = 1'b0;
    hz.Forward1E = fwd_sel(hz.RegReadE[1], hz.Rs1E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    hz.Forward2E = fwd_sel(hz.RegReadE[0], hz.Rs2E, hz.RdM, hz.RegWriteM, hz.RdW, hz.RegWriteW);
    if (rst) begin
      hz.FlushD    = 1'b1;
      hz.FlushE    = 1'b1;
      hz.FlushM    = 1'b1;
      hz.FlushW    = 1'b1;
      hz.Forward1E = 2'b00;
      hz.Forward2E = 2'b00;
    end else if (memstall) begin
      // Freeze F..M. Feed a bubble into WB so the stalled MEM result is not
      // written twice. Redirects and load-use are re-evaluated after release.
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.StallE = 1'b1;
      hz.StallM = 1'b1;
      hz.FlushW = 1'b1;
    end else if (redirect) begin
      // A taken branch or jalr squashes ID, so a load-use in ID needs no stall.
      hz.FlushD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (load_use) begin
      hz.StallF = 1'b1;
      hz.StallD = 1'b1;
      hz.FlushE = 1'b1;
    end else if (hz.JalD) begin
      hz.FlushD = 1'b1;
    end
  end

  // ---------------------------------------------------------------- status
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (err_set)
        mem_err <= 1'b1;
      if (hz.StallD && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign hz.mem_err   = mem_err;
  assign hz.stall_cnt = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl.
// The driver applies one input vector per cycle, at posedge + 1. It computes the
// expected outputs from a behavioural model and pushes them into a queue. The
// monitor pops that queue at each negedge and compares.
module tb_hazard_ctrl;
  localparam int MEM_TIMEOUT = 4;
  localparam int CNT_W       = 4;
  localparam int CNT_MAX     = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

  hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  typedef struct {
    logic       rst;
    logic [4:0] rs1d, rs2d;
    logic [1:0] rrd;
    logic [4:0] rs1e, rs2e;
    logic [1:0] rre;
    logic [4:0] rde;
    logic       mtre;
    logic [4:0] rdm, rdw;
    logic [2:0] rwm, rww;
    logic       br, jalr, jald, req, ack;
  } stim_t;

  typedef struct {
    int               idx;
    logic [4:0]       stall;  // {F,D,E,M,W}
    logic [3:0]       flush;  // {D,E,M,W}
    logic [1:0]       f1, f2;
    logic             err;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec  = 0;
  int   n_cmp  = 0;
  int   n_miss = 0;

  // Reference model state.
  // m_waited counts the consecutive cycles that the current access has stalled.
  int m_waited = 0;
  bit m_halt   = 0;
  bit m_err    = 0;
  int m_cnt    = 0;

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_fwd(input logic used, input logic [4:0] rs, input stim_t s);
    if (!used || rs == 0) return 2'b00;
    if (s.rwm != 0 && s.rdm == rs) return 2'b10;
    if (s.rww != 0 && s.rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, rs1d: 5'd0, rs2d: 5'd0, rrd: 2'b00, rs1e: 5'd0, rs2e: 5'd0, rre: 2'b00,
          rde: 5'd0, mtre: 1'b0, rdm: 5'd0, rdw: 5'd0, rwm: 3'd0, rww: 3'd0,
          br: 1'b0, jalr: 1'b0, jald: 1'b0, req: 1'b0, ack: 1'b0};
    return s;
  endfunction

  task automatic apply(input stim_t s);
    exp_t e;
    bit   mstall, lu;
    @(posedge clk);
    #1;
    rst          = s.rst;
    hz.Rs1D      = s.rs1d;  hz.Rs2D      = s.rs2d;  hz.RegReadD  = s.rrd;
    hz.Rs1E      = s.rs1e;  hz.Rs2E      = s.rs2e;  hz.RegReadE  = s.rre;
    hz.RdE       = s.rde;   hz.MemToRegE = s.mtre;
    hz.RdM       = s.rdm;   hz.RdW       = s.rdw;
    hz.RegWriteM = s.rwm;   hz.RegWriteW = s.rww;
    hz.BranchE   = s.br;    hz.JalrE     = s.jalr;  hz.JalD      = s.jald;
    hz.dmem_req  = s.req;   hz.dmem_ack  = s.ack;

    mstall = m_halt || ((m_waited > 0) ? !s.ack : (s.req && !s.ack));
    lu     = s.mtre && s.rde != 0 &&
             ((s.rrd[1] && s.rde == s.rs1d) || (s.rrd[0] && s.rde == s.rs2d));
    e.idx   = n_vec;
    e.err   = m_err;
    e.cnt   = CNT_W'(m_cnt);
    e.f1    = ref_fwd(s.rre[1], s.rs1e, s);
    e.f2    = ref_fwd(s.rre[0], s.rs2e, s);
    e.stall = 5'b00000;
    e.flush = 4'b0000;
    if (s.rst) begin
      e.flush = 4'b1111;
      e.f1 = 2'b00;
      e.f2 = 2'b00;
    end else if (mstall) begin
      e.stall = 5'b11110;
      e.flush = 4'b0001;
    end else if (s.br || s.jalr) begin
      e.flush = 4'b1100;
    end else if (lu) begin
      e.stall = 5'b11000;
      e.flush = 4'b0100;
    end else if (s.jald) begin
      e.flush = 4'b1000;
    end
    sb_q.push_back(e);
    n_vec++;

    // Advance the model to the state after this edge.
    if (s.rst) begin
      m_waited = 0; m_halt = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (e.stall[3] && m_cnt < CNT_MAX) m_cnt++;
      if (!m_halt) begin
        if (mstall) begin
          m_waited++;
          if (m_waited == MEM_TIMEOUT) begin
            m_halt = 1; m_err = 1;
          end
        end else begin
          m_waited = 0;
        end
      end
    end
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("stall",     e.idx, 32'({hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}), 32'(e.stall));
        check("flush",     e.idx, 32'({hz.FlushD, hz.FlushE, hz.FlushM, hz.FlushW}), 32'(e.flush));
        check("fwd1",      e.idx, 32'(hz.Forward1E), 32'(e.f1));
        check("fwd2",      e.idx, 32'(hz.Forward2E), 32'(e.f2));
        check("mem_err",   e.idx, 32'(hz.mem_err), 32'(e.err));
        check("stall_cnt", e.idx, 32'(hz.stall_cnt), 32'(e.cnt));
      end
    end
  end

  // Driver
  initial begin
    stim_t s;
    s = idle();
    hz.Rs1D = 0; hz.Rs2D = 0; hz.RegReadD = 0; hz.Rs1E = 0; hz.Rs2E = 0; hz.RegReadE = 0;
    hz.RdE = 0; hz.MemToRegE = 0; hz.RdM = 0; hz.RdW = 0; hz.RegWriteM = 0; hz.RegWriteW = 0;
    hz.BranchE = 0; hz.JalrE = 0; hz.JalD = 0; hz.dmem_req = 0; hz.dmem_ack = 0;

    s.rst = 1; apply(s); apply(s);
    s = idle(); apply(s);

    // Forwarding: MEM beats WB, x0 and unused operands not forwarded
    s = idle(); s.rdm = 5; s.rwm = 1; s.rdw = 5; s.rww = 1; s.rs1e = 5; s.rre = 2'b10; apply(s);
    s.rdm = 0; apply(s);
    s.rre = 2'b01; s.rs2e = 5; s.rdm = 5; apply(s);
    s.rwm = 0; apply(s);
    s.rdw = 0; s.rs2e = 0; apply(s);

    // Load-use
    s = idle(); s.mtre = 1; s.rde = 7; s.rs2d = 7; s.rrd = 2'b01; apply(s);
    s.rde = 0; s.rs2d = 0; apply(s);
    s.rde = 7; s.rs2d = 7; s.rrd = 2'b10; apply(s);
    s.rs1d = 7; apply(s);

    // Redirect beats load-use, jal in ID
    s = idle(); s.mtre = 1; s.rde = 7; s.rs1d = 7; s.rrd = 2'b10; s.br = 1; apply(s);
    s.br = 0; s.jalr = 1; apply(s);
    s = idle(); s.jald = 1; apply(s);

    // Memory wait: three stalled cycles, then ack
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.req = 1; apply(s); apply(s); apply(s);
    s.ack = 1; apply(s);
    s = idle(); s.req = 1; s.ack = 1; apply(s);
    s = idle(); apply(s);

    // Timeout into HALT. Ack and redirects are ignored there.
    s = idle(); s.rst = 1; apply(s);
    s = idle(); s.req = 1; for (int i = 0; i < 5; i++) apply(s);
    s = idle(); s.ack = 1; s.br = 1; apply(s);
    s = idle(); apply(s);
    s.rst = 1; apply(s);
    s = idle(); apply(s);

    // Reset during MWAIT
    s = idle(); s.req = 1; apply(s); apply(s);
    s.rst = 1; apply(s);
    s = idle(); apply(s);

    // Counter saturation
    s = idle(); s.mtre = 1; s.rde = 3; s.rs1d = 3; s.rrd = 2'b10;
    for (int i = 0; i < CNT_MAX + 4; i++) apply(s);

    // Random traffic
    for (int i = 0; i < 2000; i++) begin
      s.rst  = ($urandom_range(0, 49) == 0);
      s.rs1d = 5'($urandom_range(0, 3)); s.rs2d = 5'($urandom_range(0, 3));
      s.rrd  = 2'($urandom_range(0, 3));
      s.rs1e = 5'($urandom_range(0, 3)); s.rs2e = 5'($urandom_range(0, 3));
      s.rre  = 2'($urandom_range(0, 3));
      s.rde  = 5'($urandom_range(0, 3)); s.mtre = ($urandom_range(0, 2) == 0);
      s.rdm  = 5'($urandom_range(0, 3)); s.rdw  = 5'($urandom_range(0, 3));
      s.rwm  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      s.rww  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      s.br   = ($urandom_range(0, 7) == 0);
      s.jalr = ($urandom_range(0, 15) == 0);
      s.jald = ($urandom_range(0, 7) == 0);
      s.req  = ($urandom_range(0, 3) == 0);
      s.ack  = ($urandom_range(0, 1) == 0);
      apply(s);
    end

    // Drain the scoreboard within a bounded number of cycles.
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expected responses never compared", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
